// File: rtl/multicycle_main_fsm_if.sv
// Control bundle between the multicycle main FSM and the RV32I datapath.
interface multicycle_main_fsm_if;
  logic [6:0] opcode;
  logic       zero;
  logic       PC_write;
  logic       adr_src;
  logic       mem_write;
  logic       IR_write;
  logic [1:0] result_src;
  logic [1:0] ALU_src_a;
  logic [1:0] ALU_src_b;
  logic [1:0] ALU_op;
  logic       reg_write;
  logic       instr_done;
  logic       illegal_instr;

  // FSM side: consumes opcode/zero, drives every control
  modport master (
    input  opcode, zero,
    output PC_write, adr_src, mem_write, IR_write, result_src,
           ALU_src_a, ALU_src_b, ALU_op, reg_write, instr_done, illegal_instr
  );

  // Datapath side: supplies opcode/zero, consumes the controls
  modport slave (
    output opcode, zero,
    input  PC_write, adr_src, mem_write, IR_write, result_src,
           ALU_src_a, ALU_src_b, ALU_op, reg_write, instr_done, illegal_instr
  );
endinterface

// File: rtl/multicycle_main_fsm.sv
// Main control FSM for the multicycle RV32I core (lw, sw, R, I, beq, jal).
// Controls are Moore-decoded from state; PC_write additionally follows zero
// in BEQ. Write enables are gated by reset so an abandoned instruction never
// completes a write.
module multicycle_main_fsm #(
  parameter logic [6:0] OPC_LW  = 7'b0000011,
  parameter logic [6:0] OPC_SW  = 7'b0100011,
  parameter logic [6:0] OPC_R   = 7'b0110011,
  parameter logic [6:0] OPC_I   = 7'b0010011,
  parameter logic [6:0] OPC_BEQ = 7'b1100011,
  parameter logic [6:0] OPC_JAL = 7'b1101111
) (
  input logic                  clk,
  input logic                  reset,
  multicycle_main_fsm_if.master bus
);

  localparam int unsigned STATE_W = 4;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_TRAP     = 4'd11;

  logic [STATE_W-1:0] state_q, state_d;
  logic               illegal_q, illegal_d;

  logic       pc_update;
  logic       branch;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       instr_done;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;

  // State register; reset parks the machine in FETCH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Sticky illegal-instruction flag, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  // Flag is raised on the DECODE -> TRAP transition
  always_comb begin
    illegal_d = illegal_q | ((state_q == S_DECODE) && (state_d == S_TRAP));
  end

  // Next-state and Moore control decode
  always_comb begin
    state_d    = state_q;
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;

    case (state_q)
      S_FETCH: begin
        state_d    = S_DECODE;
        ir_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_update  = 1'b1;
      end
      S_DECODE: begin
        // Old PC + imm precomputes the branch target into ALU-out
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        if ((bus.opcode == OPC_LW) || (bus.opcode == OPC_SW)) begin
          state_d = S_MEMADR;
        end else if (bus.opcode == OPC_R) begin
          state_d = S_EXECR;
        end else if (bus.opcode == OPC_I) begin
          state_d = S_EXECI;
        end else if (bus.opcode == OPC_BEQ) begin
          state_d = S_BEQ;
        end else if (bus.opcode == OPC_JAL) begin
          state_d = S_JAL;
        end else begin
          state_d = S_TRAP;
        end
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (bus.opcode == OPC_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b00;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        result_src = 2'b00;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b00;
        alu_op     = 2'b01;
        result_src = 2'b00;
        branch     = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        // Old PC + 4 is the link value; PC takes the target from ALU-out
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        alu_op     = 2'b00;
        result_src = 2'b00;
        pc_update  = 1'b1;
        state_d    = S_ALUWB;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Enables are masked by reset so an interrupted instruction writes nothing
  assign bus.PC_write      = ~reset & (pc_update | (branch & bus.zero));
  assign bus.IR_write      = ~reset & ir_write;
  assign bus.mem_write     = ~reset & mem_write;
  assign bus.reg_write     = ~reset & reg_write;
  assign bus.instr_done    = ~reset & instr_done;
  assign bus.adr_src       = adr_src;
  assign bus.result_src    = result_src;
  assign bus.ALU_src_a     = alu_src_a;
  assign bus.ALU_src_b     = alu_src_b;
  assign bus.ALU_op        = alu_op;
  assign bus.illegal_instr = illegal_q;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Self-checking bench for multicycle_main_fsm: a per-instruction phase list
// and a phase-to-controls table form the reference; random opcodes and zero.
module tb_multicycle_main_fsm;

  typedef enum int {P_F, P_D, P_MA, P_MR, P_MWB, P_MW, P_ER, P_EI, P_AWB,
                    P_BEQ, P_JAL, P_TRAP} phase_t;

  logic       clk = 1'b0;
  logic       reset;
  int         n_checks = 0;
  int         n_fail   = 0;
  logic       exp_illegal;
  phase_t     seq[$];
  logic [6:0] legal_ops [6] = '{7'b0000011, 7'b0100011, 7'b0110011,
                                7'b0010011, 7'b1100011, 7'b1101111};

  always #5 clk = ~clk;

  multicycle_main_fsm_if fsm_if ();

  multicycle_main_fsm dut (
    .clk  (clk),
    .reset(reset),
    .bus  (fsm_if)
  );

  logic [14:0] got;
  assign got = {fsm_if.PC_write, fsm_if.adr_src, fsm_if.mem_write, fsm_if.IR_write,
                fsm_if.result_src, fsm_if.ALU_src_a, fsm_if.ALU_src_b, fsm_if.ALU_op,
                fsm_if.reg_write, fsm_if.instr_done, fsm_if.illegal_instr};

  // Phase sequence each instruction class walks through, FETCH first
  function automatic void build_seq(input logic [6:0] op);
    case (op)
      7'b0000011: seq = '{P_F, P_D, P_MA, P_MR, P_MWB};
      7'b0100011: seq = '{P_F, P_D, P_MA, P_MW};
      7'b0110011: seq = '{P_F, P_D, P_ER, P_AWB};
      7'b0010011: seq = '{P_F, P_D, P_EI, P_AWB};
      7'b1100011: seq = '{P_F, P_D, P_BEQ};
      7'b1101111: seq = '{P_F, P_D, P_JAL, P_AWB};
      default:    seq = '{P_F, P_D, P_TRAP};
    endcase
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    for (int i = 0; i < 6; i++) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Expected control vector for a phase
  function automatic logic [14:0] model(input phase_t p, input logic z,
                                        input logic rst, input logic ill);
    logic pcw, adr, mw, irw, rw, done;
    logic [1:0] rs, a, b, op;
    {pcw, adr, mw, irw, rw, done} = 6'b0;
    rs = 2'b00; a = 2'b00; b = 2'b00; op = 2'b00;
    case (p)
      P_F:    begin irw = 1'b1; b = 2'b10; rs = 2'b10; pcw = 1'b1; end
      P_D:    begin a = 2'b01; b = 2'b01; end
      P_MA:   begin a = 2'b10; b = 2'b01; end
      P_MR:   begin adr = 1'b1; end
      P_MW:   begin adr = 1'b1; mw = 1'b1; done = 1'b1; end
      P_MWB:  begin rs = 2'b01; rw = 1'b1; done = 1'b1; end
      P_ER:   begin a = 2'b10; b = 2'b00; op = 2'b10; end
      P_EI:   begin a = 2'b10; b = 2'b01; op = 2'b10; end
      P_AWB:  begin rw = 1'b1; done = 1'b1; end
      P_BEQ:  begin a = 2'b10; op = 2'b01; pcw = z; done = 1'b1; end
      P_JAL:  begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
      default: ;
    endcase
    if (rst) begin
      pcw = 1'b0; mw = 1'b0; irw = 1'b0; rw = 1'b0; done = 1'b0;
    end
    return {pcw, adr, mw, irw, rs, a, b, op, rw, done, ill};
  endfunction

  task automatic test_reset();
    logic [14:0] exp;
    reset = 1'b1;
    fsm_if.opcode = 7'b0110011;
    fsm_if.zero = 1'b1;
    exp_illegal = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      fsm_if.zero = c[0];
      #1;
      exp = model(P_F, fsm_if.zero, 1'b1, 1'b0);
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d got=%b exp=%b", c, got, exp);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Each legal non-branch class once, every cycle compared
  task automatic test_instr_sequencing();
    logic [6:0] ops [5] = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b0010011, 7'b1101111};
    logic [14:0] exp;
    for (int i = 0; i < 5; i++) begin
      fsm_if.opcode = ops[i];
      build_seq(ops[i]);
      for (int k = 0; k < seq.size(); k++) begin
        if (k > 0) begin @(posedge clk); #1; end
        fsm_if.zero = 1'($urandom_range(0, 1));
        @(negedge clk);
        exp = model(seq[k], fsm_if.zero, 1'b0, exp_illegal);
        n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL seq op=%b step=%0d got=%b exp=%b", ops[i], k, got, exp);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  // beq with zero=1 then zero=0; PC_write tracks zero inside the BEQ cycle
  task automatic test_beq();
    logic [14:0] exp;
    fsm_if.opcode = 7'b1100011;
    build_seq(7'b1100011);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < seq.size(); k++) begin
        if (k > 0) begin @(posedge clk); #1; end
        fsm_if.zero = (seq[k] == P_BEQ) ? (r == 0) : 1'($urandom_range(0, 1));
        @(negedge clk);
        exp = model(seq[k], fsm_if.zero, 1'b0, exp_illegal);
        n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL beq run=%0d step=%0d got=%b exp=%b", r, k, got, exp);
        end
        if (seq[k] == P_BEQ) begin
          fsm_if.zero = ~fsm_if.zero;
          #1;
          n_checks++;
          if (fsm_if.PC_write !== fsm_if.zero) begin
            n_fail++;
            $display("FAIL beq_zero_follow run=%0d got=%b exp=%b", r, fsm_if.PC_write, fsm_if.zero);
          end
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] op;
    logic [14:0] exp;
    for (int i = 0; i < 30; i++) begin
      op = legal_ops[$urandom_range(0, 5)];
      fsm_if.opcode = op;
      build_seq(op);
      for (int k = 0; k < seq.size(); k++) begin
        if (k > 0) begin @(posedge clk); #1; end
        fsm_if.zero = 1'($urandom_range(0, 1));
        @(negedge clk);
        exp = model(seq[k], fsm_if.zero, 1'b0, exp_illegal);
        n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL b2b i=%0d op=%b step=%0d got=%b exp=%b", i, op, k, got, exp);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  // Async reset while in MEMWRITE drops mem_write before any clock edge
  task automatic test_reset_in_memwrite();
    logic [14:0] exp;
    fsm_if.opcode = 7'b0100011;
    build_seq(7'b0100011);
    for (int k = 0; k < seq.size(); k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      fsm_if.zero = 1'($urandom_range(0, 1));
      @(negedge clk);
      exp = model(seq[k], fsm_if.zero, 1'b0, exp_illegal);
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL memwr_seq step=%0d got=%b exp=%b", k, got, exp);
      end
    end
    #1;
    reset = 1'b1;
    exp_illegal = 1'b0;
    #1;
    exp = model(P_F, fsm_if.zero, 1'b1, 1'b0);
    n_checks++;
    if (got !== exp || fsm_if.mem_write !== 1'b0) begin
      n_fail++;
      $display("FAIL memwr_async_reset got=%b exp=%b", got, exp);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Unsupported opcode traps, flag sticks, enables stay low while zero toggles
  task automatic test_illegal(input logic [6:0] op);
    logic [14:0] exp;
    fsm_if.opcode = op;
    build_seq(op);
    for (int k = 0; k < 12; k++) seq.push_back(P_TRAP);
    for (int k = 0; k < seq.size(); k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (seq[k] == P_TRAP) exp_illegal = 1'b1;
      fsm_if.zero = k[0];
      if (k >= 3) fsm_if.opcode = 7'($urandom);
      @(negedge clk);
      exp = model(seq[k], fsm_if.zero, 1'b0, exp_illegal);
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL illegal op=%b step=%0d got=%b exp=%b", op, k, got, exp);
      end
      if (seq[k] == P_TRAP) begin
        fsm_if.zero = ~fsm_if.zero;
        #1;
        exp = model(P_TRAP, fsm_if.zero, 1'b0, 1'b1);
        n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL trap_zero_toggle step=%0d got=%b exp=%b", k, got, exp);
        end
      end
    end
  endtask

  // Async reset mid-cycle in TRAP clears illegal_instr at once, then recovers
  task automatic test_reset_in_trap();
    logic [14:0] exp;
    #1;
    reset = 1'b1;
    exp_illegal = 1'b0;
    #1;
    exp = model(P_F, fsm_if.zero, 1'b1, 1'b0);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL trap_async_reset got=%b exp=%b", got, exp);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    fsm_if.opcode = 7'b0110011;
    build_seq(7'b0110011);
    for (int k = 0; k < seq.size(); k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      fsm_if.zero = 1'($urandom_range(0, 1));
      @(negedge clk);
      exp = model(seq[k], fsm_if.zero, 1'b0, exp_illegal);
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL post_trap step=%0d got=%b exp=%b", k, got, exp);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [6:0] bad;
    test_reset();
    test_instr_sequencing();
    test_beq();
    test_back_to_back();
    test_reset_in_memwrite();
    test_illegal(7'b0000000);
    test_reset_in_trap();
    bad = 7'($urandom);
    while (is_legal(bad)) bad = 7'($urandom);
    test_illegal(bad);
    test_reset_in_trap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
